// File: rtl/cond_branch_ctrl.sv
// Conditional branch controller: evaluates {N,Z,C,V} conditions and emits redirect, link write and flush.
// Latency: redirect/link one cycle after acceptance; flush lasts FLUSH_CYCLES; br_ready is low outside IDLE.
module cond_branch_ctrl #(
  parameter int AW           = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flag_we,
  input  logic [3:0]    flag_in,
  input  logic          br_valid,
  output logic          br_ready,
  input  logic [3:0]    br_cond,
  input  logic [AW-1:0] br_pc,
  input  logic [AW-1:0] br_target,
  input  logic          br_link,
  output logic          redirect_valid,
  output logic [AW-1:0] redirect_pc,
  output logic          flush,
  output logic          link_we,
  output logic [AW-1:0] link_data,
  output logic [3:0]    flags_out,
  output logic [15:0]   taken_cnt,
  output logic [15:0]   nottaken_cnt
);

  typedef enum logic [1:0] {IDLE, EVAL, FLUSH} state_t;

  localparam logic [2:0]    FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [AW-1:0] LINK_OFS   = AW'(4);

  state_t     state;
  logic [3:0] flags_q;
  logic [2:0] flush_cnt;
  logic       taken_q;
  logic [3:0] eff_flags;
  logic       cond_ok;
  logic       f_n, f_z, f_c, f_v;

  assign flags_out = flags_q;

  // A flag write in the same cycle as the branch is forwarded into the evaluation.
  always_comb begin
    eff_flags = flag_we ? flag_in : flags_q;
    f_n = eff_flags[3];
    f_z = eff_flags[2];
    f_c = eff_flags[1];
    f_v = eff_flags[0];
    cond_ok = 1'b0;
    case (br_cond)
      4'h0: cond_ok = f_z;
      4'h1: cond_ok = !f_z;
      4'h2: cond_ok = f_c;
      4'h3: cond_ok = !f_c;
      4'h4: cond_ok = f_n;
      4'h5: cond_ok = !f_n;
      4'h6: cond_ok = f_v;
      4'h7: cond_ok = !f_v;
      4'h8: cond_ok = f_c && !f_z;
      4'h9: cond_ok = !f_c || f_z;
      4'hA: cond_ok = (f_n == f_v);
      4'hB: cond_ok = (f_n != f_v);
      4'hC: cond_ok = !f_z && (f_n == f_v);
      4'hD: cond_ok = f_z || (f_n != f_v);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      flags_q        <= 4'h0;
      flush_cnt      <= 3'd0;
      taken_q        <= 1'b0;
      br_ready       <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      link_we        <= 1'b0;
      link_data      <= '0;
      taken_cnt      <= 16'h0;
      nottaken_cnt   <= 16'h0;
    end else begin
      if (flag_we)
        flags_q <= flag_in;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      link_we        <= 1'b0;
      link_data      <= '0;
      case (state)
        IDLE: begin
          br_ready <= 1'b1;
          flush    <= 1'b0;
          // Pulse outputs are registered here so they appear exactly in the EVAL cycle.
          if (br_valid && br_ready) begin
            state    <= EVAL;
            br_ready <= 1'b0;
            taken_q  <= cond_ok;
            if (cond_ok) begin
              redirect_valid <= 1'b1;
              redirect_pc    <= br_target;
              flush          <= 1'b1;
              link_we        <= br_link;
              link_data      <= br_link ? (br_pc + LINK_OFS) : '0;
            end
          end
        end
        EVAL: begin
          if (taken_q) begin
            if (taken_cnt != 16'hFFFF)
              taken_cnt <= taken_cnt + 16'd1;
            if (FLUSH_CYCLES == 1) begin
              state    <= IDLE;
              flush    <= 1'b0;
              br_ready <= 1'b1;
            end else begin
              state     <= FLUSH;
              flush_cnt <= FLUSH_LOAD;
            end
          end else begin
            if (nottaken_cnt != 16'hFFFF)
              nottaken_cnt <= nottaken_cnt + 16'd1;
            state    <= IDLE;
            br_ready <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt == 3'd1) begin
            state     <= IDLE;
            flush     <= 1'b0;
            br_ready  <= 1'b1;
            flush_cnt <= 3'd0;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cond_branch_ctrl.sv
// Directed bench for cond_branch_ctrl: default instance (FLUSH_CYCLES=2) and a FLUSH_CYCLES=1 instance.
module tb_cond_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flag_we;
  logic [3:0]  flag_in;
  logic        br_valid, br_valid1;
  logic [3:0]  br_cond;
  logic [31:0] br_pc, br_target;
  logic        br_link;

  logic        br_ready, redirect_valid, flush, link_we;
  logic [31:0] redirect_pc, link_data;
  logic [3:0]  flags_out;
  logic [15:0] taken_cnt, nottaken_cnt;

  logic        br_ready1, redirect_valid1, flush1, link_we1;
  logic [31:0] redirect_pc1, link_data1;
  logic [3:0]  flags_out1;
  logic [15:0] taken_cnt1, nottaken_cnt1;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_t    = 0;
  int exp_nt   = 0;

  always #5 clk = ~clk;

  cond_branch_ctrl #(.AW(32), .FLUSH_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_in(flag_in),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_pc(br_pc),
    .br_target(br_target), .br_link(br_link), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .link_we(link_we), .link_data(link_data),
    .flags_out(flags_out), .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
  );

  cond_branch_ctrl #(.AW(32), .FLUSH_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_in(flag_in),
    .br_valid(br_valid1), .br_ready(br_ready1), .br_cond(br_cond), .br_pc(br_pc),
    .br_target(br_target), .br_link(br_link), .redirect_valid(redirect_valid1),
    .redirect_pc(redirect_pc1), .flush(flush1), .link_we(link_we1), .link_data(link_data1),
    .flags_out(flags_out1), .taken_cnt(taken_cnt1), .nottaken_cnt(nottaken_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Odd codes are the inverse of the preceding even code; 7 pairs AL/NV.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy & ~z;
      3'd5: b = (n == v);
      3'd6: b = ~z & (n == v);
      default: b = 1'b1;
    endcase
    return b ^ c[0];
  endfunction

  task automatic write_flags(input logic [3:0] f);
    flag_we = 1'b1;
    flag_in = f;
    @(negedge clk);
    flag_we = 1'b0;
    check("flags_wr", {28'h0, flags_out}, {28'h0, f});
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!br_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rdy_wait", {31'h0, br_ready}, 32'h1);
  endtask

  task automatic do_branch(input logic [3:0] cond, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic lnk, input logic fwe, input logic [3:0] fin,
                           input logic tk, input string tag);
    logic [31:0] e_rpc, e_ldat;
    logic        e_lwe;
    e_rpc  = tk ? tgt : 32'h0;
    e_lwe  = tk & lnk;
    e_ldat = e_lwe ? (pc + 32'd4) : 32'h0;
    wait_ready();
    br_valid = 1'b1; br_cond = cond; br_pc = pc; br_target = tgt; br_link = lnk;
    flag_we = fwe; flag_in = fin;
    @(negedge clk);
    br_valid = 1'b0; flag_we = 1'b0;
    check({tag, "_rv"},   {31'h0, redirect_valid}, {31'h0, tk});
    check({tag, "_rpc"},  redirect_pc, e_rpc);
    check({tag, "_fl1"},  {31'h0, flush}, {31'h0, tk});
    check({tag, "_lwe"},  {31'h0, link_we}, {31'h0, e_lwe});
    check({tag, "_ldat"}, link_data, e_ldat);
    if (tk) begin
      exp_t++;
      @(negedge clk);
      check({tag, "_fl2"},  {31'h0, flush}, 32'h1);
      check({tag, "_rdy2"}, {31'h0, br_ready}, 32'h0);
      check({tag, "_rv2"},  {31'h0, redirect_valid}, 32'h0);
      @(negedge clk);
      check({tag, "_fl3"},  {31'h0, flush}, 32'h0);
      check({tag, "_rdy3"}, {31'h0, br_ready}, 32'h1);
    end else begin
      exp_nt++;
      @(negedge clk);
      check({tag, "_nfl"},  {31'h0, flush}, 32'h0);
      check({tag, "_nrdy"}, {31'h0, br_ready}, 32'h1);
    end
  endtask

  initial begin
    int bad;
    int accepts;
    int cyc;
    rst_n = 1'b0; flag_we = 1'b0; flag_in = 4'h0; br_valid = 1'b0; br_valid1 = 1'b0;
    br_cond = 4'h0; br_pc = 32'h0; br_target = 32'h0; br_link = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_rdy",   {31'h0, br_ready}, 32'h0);
    check("rst_flags", {28'h0, flags_out}, 32'h0);
    check("rst_tcnt",  {16'h0, taken_cnt}, 32'h0);
    check("rst_ncnt",  {16'h0, nottaken_cnt}, 32'h0);
    check("rst_rv",    {31'h0, redirect_valid}, 32'h0);
    check("rst_fl",    {31'h0, flush}, 32'h0);
    check("rst_ldat",  link_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_rdy", {31'h0, br_ready}, 32'h1);

    // BEQ taken with link, default flush length.
    write_flags(4'b0100);
    do_branch(4'h0, 32'h40, 32'h100, 1'b1, 1'b0, 4'h0, 1'b1, "beq");
    check("beq_tcnt", {16'h0, taken_cnt}, 32'h1);

    // Flag forwarding in the same cycle as the request.
    write_flags(4'b0000);
    do_branch(4'h0, 32'h80, 32'h200, 1'b0, 1'b1, 4'b0100, 1'b1, "fwd");
    check("fwd_flags", {28'h0, flags_out}, 32'h4);

    // Every condition code against every flag value.
    for (int f = 0; f < 16; f++) begin
      write_flags(4'(f));
      for (int c = 0; c < 16; c++)
        do_branch(4'(c), 32'h1000 + 32'(c * 4), 32'h2000 + 32'(f * 64), c[0], 1'b0, 4'h0,
                  ref_cond(4'(c), 4'(f)), "cc");
    end
    check("sum_tcnt", {16'h0, taken_cnt}, 32'(exp_t));
    check("sum_ncnt", {16'h0, nottaken_cnt}, 32'(exp_nt));

    do_branch(4'hE, 32'hFFFF_FFFC, 32'h300, 1'b1, 1'b0, 4'h0, 1'b1, "wrap");

    // Reset in the middle of a flush.
    write_flags(4'b0100);
    wait_ready();
    br_valid = 1'b1; br_cond = 4'h0; br_pc = 32'h50; br_target = 32'h400; br_link = 1'b1;
    @(negedge clk);
    br_valid = 1'b0;
    check("mid_fl1", {31'h0, flush}, 32'h1);
    @(negedge clk);
    check("mid_fl2", {31'h0, flush}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_fl",    {31'h0, flush}, 32'h0);
    check("mid_rst_rdy",   {31'h0, br_ready}, 32'h0);
    check("mid_rst_flags", {28'h0, flags_out}, 32'h0);
    check("mid_rst_tcnt",  {16'h0, taken_cnt}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_t = 0; exp_nt = 0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (redirect_valid || flush || link_we) bad++;
    end
    check("post_rst_quiet", 32'(bad), 32'h0);
    check("post_rst_rdy", {31'h0, br_ready}, 32'h1);

    // Single-cycle flush instance.
    check("f1_rdy0", {31'h0, br_ready1}, 32'h1);
    br_valid1 = 1'b1; br_cond = 4'hE; br_pc = 32'h60; br_target = 32'h500; br_link = 1'b0;
    @(negedge clk);
    br_valid1 = 1'b0;
    check("f1_rv",  {31'h0, redirect_valid1}, 32'h1);
    check("f1_rpc", redirect_pc1, 32'h500);
    check("f1_fl1", {31'h0, flush1}, 32'h1);
    check("f1_lwe", {31'h0, link_we1}, 32'h0);
    @(negedge clk);
    check("f1_fl2",  {31'h0, flush1}, 32'h0);
    check("f1_rdy2", {31'h0, br_ready1}, 32'h1);
    check("f1_tcnt", {16'h0, taken_cnt1}, 32'h1);

    // Saturation: 65539 more taken branches, 65540 in total.
    br_valid1 = 1'b1;
    accepts = 0;
    cyc = 0;
    while (accepts < 65539 && cyc < 140000) begin
      if (br_ready1) accepts++;
      @(negedge clk);
      cyc++;
    end
    br_valid1 = 1'b0;
    check("sat_accepts", 32'(accepts), 32'd65539);
    repeat (3) @(negedge clk);
    check("sat_tcnt", {16'h0, taken_cnt1}, 32'h0000_FFFF);
    check("sat_ncnt", {16'h0, nottaken_cnt1}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_branch_ctrl.md
COND_BRANCH_CTRL -- requirements
Module: cond_branch_ctrl

Interface
REQ-001 SHALL have parameter AW, default 32: address/PC width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2: flush length in cycles, legal range 1..7.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port flag_we, input, 1: write flags register this cycle.
REQ-006 SHALL have port flag_in, input, 4: new flags {N,Z,C,V}, N at bit 3.
REQ-007 SHALL have port br_valid, input, 1: branch request present.
REQ-008 SHALL have port br_ready, output, 1: controller can accept a branch.
REQ-009 SHALL have port br_cond, input, 4: condition code.
REQ-010 SHALL have port br_pc, input, AW: PC of the branch instruction.
REQ-011 SHALL have port br_target, input, AW: branch target.
REQ-012 SHALL have port br_link, input, 1: branch-and-link request.
REQ-013 SHALL have port redirect_valid, output, 1: one-cycle PC redirect pulse.
REQ-014 SHALL have port redirect_pc, output, AW: redirect address.
REQ-015 SHALL have port flush, output, 1: squash younger pipeline stages.
REQ-016 SHALL have port link_we, output, 1: one-cycle link-register write pulse.
REQ-017 SHALL have port link_data, output, AW: return address.
REQ-018 SHALL have port flags_out, output, 4: current flags register.
REQ-019 SHALL have port taken_cnt, output, 16: saturating count of taken branches.
REQ-020 SHALL have port nottaken_cnt, output, 16: saturating count of not-taken branches.

Function
REQ-021 SHALL update the flags register on every rising edge with flag_we=1, in any state.
REQ-022 SHALL evaluate br_cond against the effective flags: flag_in when flag_we=1 in the same cycle (forwarding), otherwise the flags register.
REQ-023 SHALL decode conditions as follows.
- 0 EQ: Z.
- 1 NE: !Z.
- 2 CS: C.
- 3 CC: !C.
- 4 MI: N.
- 5 PL: !N.
- 6 VS: V.
- 7 VC: !V.
- 8 HI: C&!Z.
- 9 LS: !C|Z.
- A GE: N==V.
- B LT: N!=V.
- C GT: !Z&(N==V).
- D LE: Z|(N!=V).
- E AL: 1.
- F NV: 0.
REQ-024 SHALL implement a state machine with states IDLE, EVAL and FLUSH.
REQ-025 SHALL drive br_ready=1 only in IDLE.
REQ-026 SHALL accept a branch at IDLE when br_valid=1; on acceptance it captures the condition result, br_pc, br_target and br_link, and goes to EVAL.
REQ-027 SHALL treat any br_valid outside IDLE as not accepted; the requester holds its inputs.
REQ-028 SHALL, in EVAL with a taken branch (cycle T+1 after acceptance at T), assert the following for exactly one cycle.
- redirect_valid=1.
- redirect_pc equal to the captured target.
- flush=1.
- link_we equal to the captured link bit.
- link_data equal to (captured pc + 4) modulo 2^AW.
REQ-029 SHALL, in EVAL with a taken branch, load the flush counter with FLUSH_CYCLES-1 and go to FLUSH, or go to IDLE directly when FLUSH_CYCLES=1.
REQ-030 SHALL, in FLUSH, hold flush=1, decrement the counter each cycle, and go to IDLE in the cycle the counter is 1.
REQ-031 SHALL produce a total flush length of exactly FLUSH_CYCLES cycles, starting at T+1.
REQ-032 SHALL, in EVAL with a not-taken branch, assert no redirect, flush or link signals and go to IDLE, so that br_ready=1 again at T+2.
REQ-033 SHALL re-assert br_ready for a taken branch at T+1+FLUSH_CYCLES.
REQ-034 SHALL increment taken_cnt or nottaken_cnt in the EVAL cycle, saturating at 0xFFFF with no wrap.
REQ-035 SHALL drive redirect_pc and link_data to 0 whenever their corresponding valid/write strobe is 0.

Reset
REQ-036 SHALL, on rst_n=0 (asynchronous, also mid-EVAL or mid-FLUSH), force the following immediately.
- State to IDLE.
- Flags to 0000.
- Counters and flush counter to 0.
- br_ready=0 while reset is held, and 1 at the first clock after rst_n rises.
- redirect_valid, flush and link_we to 0; all other outputs to 0.
REQ-037 SHALL discard a branch in progress when reset interrupts it, with no redirect after reset release.

Verification
REQ-038 SHALL cover: flag_we with flag_in=0100, then BEQ (cond 0), target 0x100, pc 0x40, link=1 -> at T+1 redirect_valid=1, redirect_pc=0x100, link_we=1, link_data=0x44, flush=1 for 2 cycles, br_ready=1 at T+3, taken_cnt=1.
REQ-039 SHALL cover: flags 0000 with flag_we=1 and flag_in=0100 in the same cycle as a BEQ request -> branch taken via forwarding.
REQ-040 SHALL cover: every cond code 0..F across all 16 flag values -> taken/not-taken matches REQ-023; not-taken branches show br_ready back at T+2 with no flush.
REQ-041 SHALL cover: pc=0xFFFFFFFC, AL, link=1 -> link_data=0x00000000.
REQ-042 SHALL cover: rst_n pulsed low during FLUSH -> flush=0 immediately, no redirect afterwards, flags_out=0000.
REQ-043 SHALL cover: 65540 taken branches -> taken_cnt=0xFFFF; FLUSH_CYCLES=1 -> flush for a single cycle and br_ready at T+2.
